// File: rtl/bcd_counter_stage_if.sv
// bcd_counter_stage_if: control inputs and BCD/status outputs of the two-digit counter stage
interface bcd_counter_stage_if;
  logic       EN;
  logic       UP;
  logic       LOAD;
  logic [7:0] LOAD_VAL;
  logic [3:0] BCD_ONES;
  logic [3:0] BCD_TENS;
  logic       TICK;
  logic       WRAP;
  logic       LOAD_ERR;
  modport master (output EN, UP, LOAD, LOAD_VAL, input BCD_ONES, BCD_TENS, TICK, WRAP, LOAD_ERR);
  modport slave (input EN, UP, LOAD, LOAD_VAL, output BCD_ONES, BCD_TENS, TICK, WRAP, LOAD_ERR);
endinterface

// File: rtl/bcd_counter_stage.sv
// bcd_counter_stage: prescaled, loadable 00-99 BCD up/down counter with tick, wrap and load-error status
// Define BCD_CNT_SATURATE_EN to saturate at 99/00 instead of wrapping (WRAP then stays 0).
module bcd_counter_stage #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic MAX10_CLK1_50,
  input logic RST,
  bcd_counter_stage_if.slave b
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] pc;
  logic t, ok, hit;
  logic [3:0] ones_n, tens_n;
  always_comb begin
    t = b.EN && pc == W'(TICK_DIV - 1);
    ok = b.LOAD_VAL[7:4] <= 4'd9 && b.LOAD_VAL[3:0] <= 4'd9;
    hit = b.UP ? (b.BCD_TENS == 4'd9 && b.BCD_ONES == 4'd9) : (b.BCD_TENS == 4'd0 && b.BCD_ONES == 4'd0);
    ones_n = b.UP ? (b.BCD_ONES == 4'd9 ? 4'd0 : b.BCD_ONES + 4'd1)
                  : (b.BCD_ONES == 4'd0 ? 4'd9 : b.BCD_ONES - 4'd1);
    tens_n = b.UP ? (b.BCD_ONES != 4'd9 ? b.BCD_TENS : b.BCD_TENS == 4'd9 ? 4'd0 : b.BCD_TENS + 4'd1)
                  : (b.BCD_ONES != 4'd0 ? b.BCD_TENS : b.BCD_TENS == 4'd0 ? 4'd9 : b.BCD_TENS - 4'd1);
  end
  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      pc <= '0;
      b.BCD_ONES <= 4'd0;
      b.BCD_TENS <= 4'd0;
      b.TICK <= 1'b0;
      b.WRAP <= 1'b0;
      b.LOAD_ERR <= 1'b0;
    end else begin
      b.TICK <= 1'b0;
      b.WRAP <= 1'b0;
      // a rejected load freezes pc, but a terminal count still rolls it over
      if (t) pc <= '0;
      else if (b.EN && !b.LOAD) pc <= pc + W'(1);
      if (b.LOAD && ok) begin
        b.BCD_TENS <= b.LOAD_VAL[7:4];
        b.BCD_ONES <= b.LOAD_VAL[3:0];
        b.LOAD_ERR <= 1'b0;
        pc <= '0;
      end else if (b.LOAD) begin
        b.LOAD_ERR <= 1'b1;
      end else if (t) begin
        b.TICK <= 1'b1;
`ifdef BCD_CNT_SATURATE_EN
        if (!hit) begin
          b.BCD_ONES <= ones_n;
          b.BCD_TENS <= tens_n;
        end
`else
        b.BCD_ONES <= ones_n;
        b.BCD_TENS <= tens_n;
        b.WRAP <= hit;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcd_counter_stage.sv
// tb_bcd_counter_stage: directed and randomized checks of bcd_counter_stage against an integer count model
module tb_bcd_counter_stage;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int bad = 0;
  int m_cnt, m_pc;
  bit m_tick, m_wrap, m_err;
  bcd_counter_stage_if b();
  bcd_counter_stage #(.TICK_DIV(DIV)) dut (.MAX10_CLK1_50(clk), .RST(rst), .b(b.slave));
  always #5 clk = ~clk;

  function automatic logic [10:0] expv();
    return {4'(m_cnt / 10), 4'(m_cnt % 10), m_tick, m_wrap, m_err};
  endfunction

  function automatic logic [10:0] got();
    return {b.BCD_TENS, b.BCD_ONES, b.TICK, b.WRAP, b.LOAD_ERR};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pc = 0; m_tick = 0; m_wrap = 0; m_err = 0;
  endtask

  // one clock edge: the model applies the counter rules to the inputs held before the edge
  task automatic step();
    bit t, ok;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      t = b.EN && m_pc == DIV - 1;
      ok = b.LOAD_VAL[7:4] < 10 && b.LOAD_VAL[3:0] < 10;
      m_tick = 0; m_wrap = 0;
      if (t) m_pc = 0;
      else if (b.EN && !b.LOAD) m_pc = m_pc + 1;
      if (b.LOAD && ok) begin
        m_cnt = b.LOAD_VAL[7:4] * 10 + b.LOAD_VAL[3:0]; m_pc = 0; m_err = 0;
      end else if (b.LOAD) m_err = 1;
      else if (t) begin
        m_tick = 1;
`ifdef BCD_CNT_SATURATE_EN
        if (b.UP) m_cnt = m_cnt == 99 ? 99 : m_cnt + 1;
        else m_cnt = m_cnt == 0 ? 0 : m_cnt - 1;
`else
        m_wrap = b.UP ? m_cnt == 99 : m_cnt == 0;
        m_cnt = (m_cnt + (b.UP ? 1 : 99)) % 100;
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; b.EN = 0; b.UP = 1; b.LOAD = 0; b.LOAD_VAL = 0;
    repeat (2) step();
    vec++; if (got() !== 11'h0) begin bad++; $display("FAIL reset_state got %h want 000", got()); end
    rst = 0; b.LOAD = 1; b.LOAD_VAL = 8'h37; step();
    b.LOAD = 0; b.EN = 1; repeat (2) step();
    vec++; if (got() !== expv() || got() !== {8'h37, 3'b000}) begin bad++; $display("FAIL load37 got %h want %h", got(), expv()); end
    #2 rst = 1; #1;
    vec++; if (got() !== 11'h0) begin bad++; $display("FAIL async_reset got %h want 000", got()); end
    step(); rst = 0; b.EN = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      vec++; if (got() !== expv() || got() !== 11'h0) begin bad++; $display("FAIL idle cyc %0d got %h want 000", i, got()); end
    end
  endtask

  task automatic test_up_count();
    b.EN = 1; b.UP = 1;
    for (int i = 1; i <= 10; i++) begin
      for (int k = 1; k <= DIV; k++) begin
        step();
        vec++; if (got() !== expv()) begin bad++; $display("FAIL up step %0d cyc %0d got %h want %h", i, k, got(), expv()); end
      end
      vec++; if (b.TICK !== 1'b1 || b.BCD_TENS !== 4'(i / 10) || b.BCD_ONES !== 4'(i % 10))
        begin bad++; $display("FAIL up_value %0d got %h%h tick %b", i, b.BCD_TENS, b.BCD_ONES, b.TICK); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] lv [2] = '{8'h98, 8'h01};
    for (int d = 0; d < 2; d++) begin
      b.UP = d == 0; b.LOAD = 1; b.LOAD_VAL = lv[d]; step();
      b.LOAD = 0;
      for (int k = 1; k <= 2 * DIV + 1; k++) begin
        step();
        vec++; if (got() !== expv()) begin bad++; $display("FAIL wrap dir %0d cyc %0d got %h want %h", d, k, got(), expv()); end
        if (k == 2 * DIV) begin
`ifdef BCD_CNT_SATURATE_EN
          vec++; if ({b.BCD_TENS, b.BCD_ONES, b.WRAP} !== {d == 0 ? 8'h99 : 8'h00, 1'b0})
`else
          vec++; if ({b.BCD_TENS, b.BCD_ONES, b.WRAP} !== {d == 0 ? 8'h00 : 8'h99, 1'b1})
`endif
            begin bad++; $display("FAIL wrap_edge dir %0d got %h%h wrap %b", d, b.BCD_TENS, b.BCD_ONES, b.WRAP); end
        end
      end
      vec++; if (b.WRAP !== 1'b0) begin bad++; $display("FAIL wrap_pulse dir %0d got %b want 0", d, b.WRAP); end
    end
  endtask

  task automatic test_load();
    logic [7:0] lv [3] = '{8'h45, 8'h4A, 8'h12};
    int first;
    b.UP = 1;
    for (int j = 0; j < 3; j++) begin
      b.LOAD = 1; b.LOAD_VAL = lv[j]; step();
      b.LOAD = 0;
      vec++; if (got() !== expv()) begin bad++; $display("FAIL load %h got %h want %h", lv[j], got(), expv()); end
    end
    vec++; if (got() !== {8'h12, 3'b000}) begin bad++; $display("FAIL load_final got %h want 090", got()); end
    first = 0;
    for (int k = 1; k <= DIV && first == 0; k++) begin
      step();
      vec++; if (got() !== expv()) begin bad++; $display("FAIL load_run cyc %0d got %h want %h", k, got(), expv()); end
      if (b.TICK) first = k;
    end
    vec++; if (first !== DIV) begin bad++; $display("FAIL load_first_tick got %0d want %0d", first, DIV); end
  endtask

  task automatic test_collision();
    for (int g = 0; g < DIV && m_pc != DIV - 1; g++) step();
    b.LOAD = 1; b.LOAD_VAL = 8'h23; step();
    b.LOAD = 0;
    vec++; if (got() !== expv() || got() !== {8'h23, 3'b000}) begin bad++; $display("FAIL collision got %h want %h", got(), expv()); end
    for (int k = 1; k <= DIV; k++) begin
      step();
      vec++; if (got() !== expv() || b.TICK !== (k == DIV)) begin bad++; $display("FAIL collision_run cyc %0d got %h want %h", k, got(), expv()); end
    end
  endtask

  task automatic test_en_gating();
    for (int g = 0; g < DIV && m_pc != DIV - 1; g++) step();
    b.EN = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      vec++; if (got() !== expv() || b.TICK !== 1'b0) begin bad++; $display("FAIL en_hold cyc %0d got %h want %h", k, got(), expv()); end
    end
    b.EN = 1;
    for (int k = 0; k <= 2 * DIV; k++) begin
      step();
      vec++; if (got() !== expv() || b.TICK !== (k % DIV == 0)) begin bad++; $display("FAIL en_resume cyc %0d got %h want %h", k, got(), expv()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      b.EN = $urandom_range(7) != 0;
      b.UP = $urandom_range(1);
      b.LOAD = $urandom_range(11) == 0;
      b.LOAD_VAL = 8'($urandom);
      step();
      vec++; if (got() !== expv()) begin bad++; $display("FAIL random cyc %0d got %h want %h", k, got(), expv()); end
      vec++; if (b.BCD_ONES > 9 || b.BCD_TENS > 9) begin bad++; $display("FAIL random_range cyc %0d got %h%h want <=99", k, b.BCD_TENS, b.BCD_ONES); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_count();
    test_wrap();
    test_load();
    test_collision();
    test_en_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/bcd_counter_stage.md
# bcd_counter_stage

Two-digit BCD up/down counter with an integrated prescaler. Produces the 4-bit BCD digits consumed directly by the BCD-to-7-segment decoder stage: one digit per decoder `SW[3:0]` input. Sits upstream of the decoders on the DE10-Lite display path. Provides a paced, loadable 00–99 count plus tick, wrap and load-error status for LEDR.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count step (1 Hz at 50 MHz); legal range ≥ 1.
- `MAX10_CLK1_50`  input  1  system clock; all state changes on its rising edge.
- `RST`  input  1  asynchronous, active-high reset.
- `EN`  input  1  count enable; when low, the prescaler and digits hold.
- `UP`  input  1  direction: 1 = increment, 0 = decrement.
- `LOAD`  input  1  synchronous load strobe, level-sampled each cycle.
- `LOAD_VAL`  input  8  `[7:4]` tens digit, `[3:0]` ones digit, both BCD.
- `BCD_ONES`  output  4  ones digit, 0–9; feeds a decoder `SW[3:0]`.
- `BCD_TENS`  output  4  tens digit, 0–9; feeds a decoder `SW[3:0]`.
- `TICK`  output  1  one-cycle pulse marking each count step.
- `WRAP`  output  1  one-cycle pulse on 99→00 (up) or 00→99 (down).
- `LOAD_ERR`  output  1  sticky flag: last load attempt carried a non-BCD digit.

## Operation
- Prescaler: counter `pc` of width ceil(log2(TICK_DIV)), minimum 1 bit.
  - When EN=1, it counts 0..TICK_DIV−1.
  - Terminal condition T = EN & (pc == TICK_DIV−1).
  - On T, pc returns to 0.
  - When EN=0, pc holds.
  - With TICK_DIV=1, T = EN every cycle.
- Count step on T, with no LOAD:
  - UP=1: ones+1. Ones 9→0 increments tens. At 99 the result is 00 and WRAP pulses.
  - UP=0: ones−1. Ones 0→9 decrements tens. At 00 the result is 99 and WRAP pulses.
- Digits never hold a value > 9 under any sequence.
- Load:
  - LOAD=1 with both `LOAD_VAL` nibbles ≤ 9: digits take `LOAD_VAL`, pc clears to 0, LOAD_ERR clears.
  - LOAD=1 with either nibble > 9: digits and pc are unchanged and LOAD_ERR sets.
- Priority, highest first: RST > LOAD > count step.
  - A step coincident with LOAD is discarded: no TICK, no WRAP.
  - A rejected load also discards a coincident step. pc still wraps to 0 on T.
- UP is sampled only on the step cycle. Changing direction takes effect at the next step.
- LOAD_ERR stays set until a valid load or RST.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Step latency: when T is true in cycle n, the new digits, TICK=1 and WRAP (if applicable) all appear after edge n+1. TICK and WRAP deassert after edge n+2 unless T recurs.
- Load latency: one edge. `LOAD_VAL` appears on `BCD_*` after the first edge where LOAD=1.
- After a valid load, the first step occurs TICK_DIV enabled cycles later.
- Reset values, asserted asynchronously, with RST released synchronously by the board-level synchroniser: BCD_ONES=0, BCD_TENS=0, TICK=0, WRAP=0, LOAD_ERR=0, pc=0.
- Reset mid-count: the partial prescaler count is lost. The first step after release occurs TICK_DIV enabled cycles after release.
- EN deasserted exactly on a terminal cycle: T is false, so no step occurs. pc stays at TICK_DIV−1 and the step fires on the first cycle EN returns high.

## Configuration
- `BCD_CNT_SATURATE_EN`
  - Defined: the counter saturates instead of wrapping. Up at 99 stays 99 and down at 00 stays 00. TICK still pulses; WRAP is tied to 0.
  - Undefined (default): wrap-around as described in Operation.

## Test plan
- Reset/idle, TICK_DIV=4: assert RST mid-count with digits at 37 → all outputs 0 immediately, without waiting for a clock edge. With EN=0 for 20 cycles after release, digits stay 00 and TICK stays 0.
- Up count, TICK_DIV=4, EN=1, UP=1 from 00 → TICK every 4th cycle. Sequence 01, 02 … 09, 10 checks the ones→tens carry.
- Wrap: load 98, UP=1 → 99, then 00 with WRAP=1 for exactly one cycle. Load 01, UP=0 → 00, then 99 with WRAP=1. With `BCD_CNT_SATURATE_EN` defined, the same stimulus holds at 99/00 and WRAP stays 0.
- Load: LOAD_VAL=8'h45 → digits 4/5 after one edge, and the next TICK comes 4 cycles later. LOAD_VAL=8'h4A → digits unchanged and LOAD_ERR=1. A subsequent LOAD_VAL=8'h12 → digits 1/2 and LOAD_ERR=0.
- Collision: LOAD=1 on the terminal cycle → digits equal LOAD_VAL, TICK=0 and WRAP=0 that edge, and pc restarts from 0.
- EN gating: drop EN on the terminal cycle for 3 cycles → no step. Restore EN → step on the first enabled cycle, then every 4 cycles.
